// File: rtl/fetch_pc_gen_pkg.sv
// fetch_pc_gen_pkg: shared widths, selection/state/correction codes for the fetch PC generator
package fetch_pc_gen_pkg;
  localparam int PC_W_DEF = 10;
  typedef enum logic [1:0] {SEL_PC1, SEL_IFPBT, SEL_CNI, SEL_EXEPBT} sel_t;
  typedef enum logic {ST_RUN, ST_REDIR} state_t;
  localparam logic [1:0] CORR_NONE = 2'b00;
  localparam logic [1:0] CORR_CNI  = 2'b10;
  localparam logic [1:0] CORR_PBT  = 2'b11;
  // code = {gated exe_correction, if_prediction}; 01x is not a real correction and falls back to PC+1
  function automatic sel_t decode_sel(input logic [2:0] code);
    return code[2] ? (code[1] ? SEL_EXEPBT : SEL_CNI) : (code == 3'b001 ? SEL_IFPBT : SEL_PC1);
  endfunction
endpackage

// File: rtl/fetch_pc_gen_next_pc_mux.sv
// next_pc_mux: combinational next fetch PC selection with modulo-2^PC_W increment
module next_pc_mux
  import fetch_pc_gen_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [2:0]      sel,
  input  logic [PC_W-1:0] if_pc,
  input  logic [PC_W-1:0] if_pbt,
  input  logic [PC_W-1:0] exe_cni,
  input  logic [PC_W-1:0] exe_pbt,
  output logic [PC_W-1:0] next_pc
);
  sel_t s;
  assign s = decode_sel(sel);
  always_comb next_pc = s == SEL_IFPBT ? if_pbt :
                        s == SEL_CNI   ? exe_cni :
                        s == SEL_EXEPBT ? exe_pbt : if_pc + PC_W'(1);
endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register and IF/ID/EXE PC+valid pipeline driven by predictor outputs
// Optional FETCH_STATS_EN adds saturating redirect / taken-prediction counters.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            stall,
  input  logic            if_prediction,
  input  logic [PC_W-1:0] if_PBT,
  input  logic [1:0]      exe_correction,
  input  logic [PC_W-1:0] exe_PBT,
  input  logic [PC_W-1:0] exe_CNI,
  input  logic            flush,
  output logic [PC_W-1:0] if_PC,
  output logic [PC_W-1:0] id_PC,
  output logic [PC_W-1:0] exe_PC,
  output logic            id_valid,
  output logic            exe_valid,
  output logic            id_pred,
  output logic            exe_pred,
  output logic            redirect,
  output logic [15:0]     redirect_count,
  output logic [15:0]     taken_pred_count
);
  state_t state, state_nxt;
  logic [1:0] corr_g;
  logic corr, adv;
  logic [PC_W-1:0] next_pc;
  assign corr_g = (exe_valid && state == ST_RUN) ? exe_correction : CORR_NONE;
  assign corr = corr_g[1];
  assign adv = corr || !stall;
  assign redirect = corr;
  next_pc_mux #(.PC_W(PC_W)) u_mux (
    .sel     ({corr_g, if_prediction}),
    .if_pc   (if_PC),
    .if_pbt  (if_PBT),
    .exe_cni (exe_CNI),
    .exe_pbt (exe_PBT),
    .next_pc (next_pc)
  );
  always_comb state_nxt = corr ? ST_REDIR : ST_RUN;
  always_ff @(posedge CLK) state <= rst ? ST_RUN : state_nxt;
  always_ff @(posedge CLK) begin
    if (rst) begin
      if_PC     <= RESET_PC;
      id_PC     <= '0;
      exe_PC    <= '0;
      id_valid  <= 1'b0;
      exe_valid <= 1'b0;
      id_pred   <= 1'b0;
      exe_pred  <= 1'b0;
    end else if (adv) begin
      if_PC     <= next_pc;
      id_PC     <= if_PC;
      id_pred   <= if_prediction;
      id_valid  <= !corr && !flush;
      exe_PC    <= id_PC;
      exe_pred  <= id_pred;
      exe_valid <= !corr && id_valid;
    end else begin
      exe_PC    <= id_PC;
      exe_valid <= 1'b0;
      if (flush) id_valid <= 1'b0;
    end
  end
`ifdef FETCH_STATS_EN
  always_ff @(posedge CLK) begin
    if (rst) begin
      redirect_count   <= '0;
      taken_pred_count <= '0;
    end else begin
      if (corr && redirect_count != 16'hFFFF) redirect_count <= redirect_count + 16'd1;
      if (!corr && !stall && if_prediction && taken_pred_count != 16'hFFFF)
        taken_pred_count <= taken_pred_count + 16'd1;
    end
  end
`else
  assign redirect_count   = '0;
  assign taken_pred_count = '0;
`endif
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed and randomized checks of fetch_pc_gen against a behavioural model
module tb_fetch_pc_gen;
  localparam int W = 10;
  logic CLK = 1'b0;
  logic rst, stall, if_prediction, flush;
  logic [W-1:0] if_PBT, exe_PBT, exe_CNI;
  logic [1:0] exe_correction;
  logic [W-1:0] if_PC, id_PC, exe_PC;
  logic id_valid, exe_valid, id_pred, exe_pred, redirect;
  logic [15:0] redirect_count, taken_pred_count;
  int checks = 0, errors = 0;
  logic [W-1:0] m_if, m_id_pc, m_ex_pc;
  logic m_id_v, m_id_p, m_ex_v, m_ex_p, m_redir;
  int m_rc, m_tc;

  fetch_pc_gen dut (
    .CLK(CLK), .rst(rst), .stall(stall), .if_prediction(if_prediction), .if_PBT(if_PBT),
    .exe_correction(exe_correction), .exe_PBT(exe_PBT), .exe_CNI(exe_CNI), .flush(flush),
    .if_PC(if_PC), .id_PC(id_PC), .exe_PC(exe_PC), .id_valid(id_valid), .exe_valid(exe_valid),
    .id_pred(id_pred), .exe_pred(exe_pred), .redirect(redirect),
    .redirect_count(redirect_count), .taken_pred_count(taken_pred_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] exp_rc();
`ifdef FETCH_STATS_EN
    return m_rc[15:0];
`else
    return 16'h0;
`endif
  endfunction

  function automatic logic [15:0] exp_tc();
`ifdef FETCH_STATS_EN
    return m_tc[15:0];
`else
    return 16'h0;
`endif
  endfunction

  function automatic logic exp_redirect();
    return m_ex_v && exe_correction[1] && !m_redir;
  endfunction

  task automatic drive(input logic r, input logic s, input logic p, input logic [W-1:0] pbt,
                       input logic [1:0] c, input logic [W-1:0] epbt, input logic [W-1:0] cni,
                       input logic f);
    rst = r; stall = s; if_prediction = p; if_PBT = pbt;
    exe_correction = c; exe_PBT = epbt; exe_CNI = cni; flush = f;
    #1;
  endtask

  task automatic tick();
    logic corr;
    logic [1:0] gc;
    logic [W-1:0] nx;
    if (rst) begin
      m_if = '0; m_id_pc = '0; m_ex_pc = '0;
      m_id_v = 0; m_id_p = 0; m_ex_v = 0; m_ex_p = 0; m_redir = 0; m_rc = 0; m_tc = 0;
    end else begin
      gc = m_ex_v ? exe_correction : 2'b00;
      corr = gc[1];
      if (corr) nx = gc[0] ? exe_PBT : exe_CNI;
      else if (if_prediction && gc == 2'b00) nx = if_PBT;
      else nx = m_if + 10'd1;
      if (corr || !stall) begin
        m_ex_pc = m_id_pc; m_ex_p = m_id_p; m_ex_v = !corr && m_id_v;
        m_id_pc = m_if; m_id_p = if_prediction; m_id_v = !corr && !flush;
        m_if = nx;
        if (!corr && if_prediction && m_tc < 65535) m_tc++;
      end else begin
        m_ex_pc = m_id_pc; m_ex_v = 0;
        if (flush) m_id_v = 0;
      end
      if (corr && m_rc < 65535) m_rc++;
      m_redir = corr;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, '0, 2'b00, '0, '0, 0);
    tick(); tick();
    checks++; if (if_PC !== 10'h000) begin errors++; $display("FAIL reset_if_pc: got %h want 000", if_PC); end
    checks++; if (id_valid !== 1'b0 || exe_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b%b want 00", id_valid, exe_valid); end
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b want 0", redirect); end
    checks++; if (redirect_count !== 16'h0 || taken_pred_count !== 16'h0) begin errors++; $display("FAIL reset_counters: got %h %h want 0 0", redirect_count, taken_pred_count); end
  endtask

  task automatic test_sequential();
    logic [W-1:0] want;
    for (int k = 1; k <= 3; k++) begin
      drive(0, 0, 0, '0, 2'b00, '0, '0, 0);
      tick();
      want = W'(k);
      checks++; if (if_PC !== want) begin errors++; $display("FAIL seq_if_pc: got %h want %h", if_PC, want); end
      checks++; if (id_valid !== 1'b1 || exe_valid !== (k >= 2)) begin errors++; $display("FAIL seq_valid k=%0d: got %b%b want 1%b", k, id_valid, exe_valid, k >= 2); end
    end
  endtask

  task automatic test_pred_taken();
    drive(0, 0, 0, '0, 2'b00, '0, '0, 0);
    tick(); tick();
    checks++; if (if_PC !== 10'h005) begin errors++; $display("FAIL pred_setup: got %h want 005", if_PC); end
    drive(0, 0, 1, 10'h040, 2'b00, '0, '0, 0);
    tick();
    checks++; if (if_PC !== 10'h040) begin errors++; $display("FAIL pred_if_pc: got %h want 040", if_PC); end
    checks++; if (id_PC !== 10'h005 || id_pred !== 1'b1) begin errors++; $display("FAIL pred_id: got %h/%b want 005/1", id_PC, id_pred); end
    checks++; if (taken_pred_count !== exp_tc()) begin errors++; $display("FAIL pred_count: got %h want %h", taken_pred_count, exp_tc()); end
  endtask

  task automatic test_correction_stall();
    drive(0, 0, 1, 10'h010, 2'b00, '0, '0, 0);
    tick();
    drive(0, 0, 0, '0, 2'b00, '0, '0, 0);
    tick(); tick();
    checks++; if (exe_PC !== 10'h010 || exe_valid !== 1'b1) begin errors++; $display("FAIL corr_setup: got %h/%b want 010/1", exe_PC, exe_valid); end
    drive(0, 1, 0, '0, 2'b11, 10'h080, 10'h123, 0);
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL corr_redirect: got %b want 1", redirect); end
    tick();
    checks++; if (if_PC !== 10'h080) begin errors++; $display("FAIL corr_if_pc: got %h want 080", if_PC); end
    checks++; if (id_valid !== 1'b0 || exe_valid !== 1'b0) begin errors++; $display("FAIL corr_squash: got %b%b want 00", id_valid, exe_valid); end
    drive(0, 0, 0, '0, 2'b10, '0, 10'h123, 0);
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL redir_ignore: got %b want 0", redirect); end
    tick();
    checks++; if (if_PC !== 10'h081) begin errors++; $display("FAIL redir_next: got %h want 081", if_PC); end
  endtask

  task automatic test_cni();
    drive(0, 0, 0, '0, 2'b00, '0, '0, 0);
    tick();
    checks++; if (exe_valid !== 1'b1) begin errors++; $display("FAIL cni_setup: got %b want 1", exe_valid); end
    drive(0, 0, 0, '0, 2'b10, 10'h3AA, 10'h011, 0);
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL cni_redirect: got %b want 1", redirect); end
    tick();
    checks++; if (if_PC !== 10'h011) begin errors++; $display("FAIL cni_if_pc: got %h want 011", if_PC); end
    drive(0, 0, 0, '0, 2'b00, '0, '0, 0);
    checks++; if (exe_valid !== 1'b0) begin errors++; $display("FAIL cni_bubble1: got %b want 0", exe_valid); end
    tick();
    checks++; if (exe_valid !== 1'b0) begin errors++; $display("FAIL cni_bubble2: got %b want 0", exe_valid); end
    tick();
    checks++; if (exe_valid !== 1'b1 || exe_PC !== 10'h011) begin errors++; $display("FAIL cni_resume: got %b/%h want 1/011", exe_valid, exe_PC); end
    checks++; if (redirect_count !== exp_rc()) begin errors++; $display("FAIL cni_count: got %h want %h", redirect_count, exp_rc()); end
  endtask

  task automatic test_wrap_stall();
    logic [W-1:0] hold_if, hold_id;
    drive(0, 0, 1, 10'h3FF, 2'b00, '0, '0, 0);
    tick();
    drive(0, 0, 0, '0, 2'b00, '0, '0, 0);
    tick();
    checks++; if (if_PC !== 10'h000) begin errors++; $display("FAIL wrap: got %h want 000", if_PC); end
    hold_if = m_if; hold_id = m_id_pc;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 10'h222, 2'b00, '0, '0, 0);
      tick();
      checks++; if (if_PC !== hold_if || id_PC !== hold_id) begin errors++; $display("FAIL stall_hold k=%0d: got %h/%h want %h/%h", k, if_PC, id_PC, hold_if, hold_id); end
      checks++; if (exe_valid !== 1'b0 || id_valid !== 1'b1) begin errors++; $display("FAIL stall_bubble k=%0d: got %b%b want 10", k, id_valid, exe_valid); end
    end
    drive(0, 0, 0, '0, 2'b00, '0, '0, 0);
    tick();
    checks++; if (exe_valid !== 1'b1 || exe_PC !== hold_id) begin errors++; $display("FAIL stall_release: got %b/%h want 1/%h", exe_valid, exe_PC, hold_id); end
  endtask

  task automatic test_reset_in_redir();
    drive(0, 0, 0, '0, 2'b11, 10'h155, '0, 0);
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL rr_redirect: got %b want 1", redirect); end
    tick();
    drive(1, 0, 1, 10'h0F0, 2'b11, 10'h155, '0, 0);
    tick();
    checks++; if (if_PC !== 10'h000) begin errors++; $display("FAIL rr_if_pc: got %h want 000", if_PC); end
    checks++; if (id_valid !== 1'b0 || exe_valid !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL rr_state: got %b%b%b want 000", id_valid, exe_valid, redirect); end
    checks++; if (redirect_count !== 16'h0 || taken_pred_count !== 16'h0) begin errors++; $display("FAIL rr_counters: got %h %h want 0 0", redirect_count, taken_pred_count); end
    drive(0, 0, 0, '0, 2'b00, '0, '0, 0);
    tick();
    checks++; if (if_PC !== 10'h001 || id_valid !== 1'b1) begin errors++; $display("FAIL rr_restart: got %h/%b want 001/1", if_PC, id_valid); end
  endtask

  task automatic test_random();
    logic [1:0] c;
    for (int n = 0; n < 400; n++) begin
      c = ($urandom_range(2) == 0) ? 2'($urandom) : 2'b00;
      drive($urandom_range(59) == 0, $urandom_range(3) == 0, 1'($urandom), W'($urandom), c,
            W'($urandom), W'($urandom), $urandom_range(5) == 0);
      checks++; if (redirect !== exp_redirect()) begin errors++; $display("FAIL rnd_redirect n=%0d: got %b want %b", n, redirect, exp_redirect()); end
      tick();
      checks++; if (if_PC !== m_if) begin errors++; $display("FAIL rnd_if_pc n=%0d: got %h want %h", n, if_PC, m_if); end
      checks++; if (id_valid !== m_id_v || exe_valid !== m_ex_v) begin errors++; $display("FAIL rnd_valid n=%0d: got %b%b want %b%b", n, id_valid, exe_valid, m_id_v, m_ex_v); end
      if (m_id_v) begin
        checks++; if (id_PC !== m_id_pc || id_pred !== m_id_p) begin errors++; $display("FAIL rnd_id n=%0d: got %h/%b want %h/%b", n, id_PC, id_pred, m_id_pc, m_id_p); end
      end
      if (m_ex_v) begin
        checks++; if (exe_PC !== m_ex_pc || exe_pred !== m_ex_p) begin errors++; $display("FAIL rnd_exe n=%0d: got %h/%b want %h/%b", n, exe_PC, exe_pred, m_ex_pc, m_ex_p); end
      end
      checks++; if (redirect_count !== exp_rc() || taken_pred_count !== exp_tc()) begin errors++; $display("FAIL rnd_counters n=%0d: got %h %h want %h %h", n, redirect_count, taken_pred_count, exp_rc(), exp_tc()); end
    end
  endtask

  initial begin
    @(posedge CLK);
    #1;
    test_reset();
    test_sequential();
    test_pred_taken();
    test_correction_stall();
    test_cni();
    test_wrap_stall();
    test_reset_in_redir();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
